// File: rtl/q_update_ctrl.sv
// Tabular Q-learning update sequencer for a 64x16 action-value RAM (16 states x 4 actions, Q8.8).
// Reads Q(s,a) and Q(s',0..3), computes the TD update, writes it back and reports the greedy action.
module q_update_ctrl #(
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  state_i,
    input  logic [1:0]  action_i,
    input  logic [3:0]  next_state_i,
    input  logic [15:0] reward_i,
    input  logic        terminal_i,
    output logic        ram_en_o,
    output logic [5:0]  ram_rd_addr_o,
    output logic [5:0]  ram_wr_addr_o,
    output logic        ram_we_o,
    output logic [15:0] ram_wdata_o,
    input  logic [15:0] ram_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  best_action_o,
    output logic [15:0] q_new_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } fsm_e;

    fsm_e       st_q, st_d;
    logic [2:0] cnt_q, cnt_d;

    logic [3:0]  s_q, sp_q;
    logic [1:0]  a_q;
    logic [15:0] r_q;
    logic        term_q;
    logic [15:0] qcur_q, max_q;
    logic [1:0]  idx_q;
    logic [5:0]  rd_addr_q, wr_addr_q;
    logic [15:0] wdata_q, q_new_q;
    logic [1:0]  best_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= S_IDLE;
            cnt_q <= 3'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        ram_en_o = 1'b0;
        ram_we_o = 1'b0;
        done_o   = 1'b0;
        busy_o   = 1'b1;
        case (st_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    st_d  = S_READ;
                    cnt_d = 3'd0;
                end
            end
            S_READ: begin
                ram_en_o = 1'b1;
                if (cnt_q == 3'd5) begin
                    st_d  = S_CALC;
                    cnt_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_CALC:  st_d = S_WRITE;
            S_WRITE: begin
                ram_we_o = 1'b1;
                st_d     = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                st_d   = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // ---------------- Update arithmetic ----------------
    logic signed [16:0] max_ext, gmax;
    logic signed [17:0] sum, delta, qcur_ext, upd_full;
    logic        [15:0] target, upd;
    logic               unused_upd_hi;

    assign max_ext  = {max_q[15], max_q};
    assign gmax     = term_q ? 17'sd0 : (max_ext - (max_ext >>> GAMMA_SHIFT));
    assign sum      = {{2{r_q[15]}}, r_q} + {gmax[16], gmax};

    always_comb begin
        target = sum[15:0];
        if (sum > 18'sd32767)
            target = 16'h7FFF;
        else if (sum < -18'sd32768)
            target = 16'h8000;
    end

    assign qcur_ext = {{2{qcur_q[15]}}, qcur_q};
    assign delta    = {{2{target[15]}}, target} - qcur_ext;
    // Result always lies between qcur and target, so the low 16 bits are exact.
    assign upd_full = qcur_ext + (delta >>> ALPHA_SHIFT);
    assign upd      = upd_full[15:0];
    assign unused_upd_hi = ^upd_full[17:16];

    // ---------------- Datapath registers ----------------
    logic [2:0] idx_from_cnt;
    assign idx_from_cnt = cnt_q - 3'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= '0;
            a_q       <= '0;
            sp_q      <= '0;
            r_q       <= '0;
            term_q    <= 1'b0;
            qcur_q    <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wdata_q   <= '0;
            q_new_q   <= '0;
            best_q    <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (start_i) begin
                        s_q       <= state_i;
                        a_q       <= action_i;
                        sp_q      <= next_state_i;
                        r_q       <= reward_i;
                        term_q    <= terminal_i;
                        rd_addr_q <= {state_i, action_i};
                    end
                end
                S_READ: begin
                    // Address for the next READ cycle; held once all four s' entries are issued.
                    if (cnt_q <= 3'd3)
                        rd_addr_q <= {sp_q, cnt_q[1:0]};
                    // Data for the address issued in the previous cycle arrives now.
                    if (cnt_q == 3'd1) begin
                        qcur_q <= ram_rdata_i;
                    end else if (cnt_q == 3'd2) begin
                        max_q <= ram_rdata_i;
                        idx_q <= 2'd0;
                    end else if (cnt_q >= 3'd3) begin
                        if ($signed(ram_rdata_i) > $signed(max_q)) begin
                            max_q <= ram_rdata_i;
                            idx_q <= idx_from_cnt[1:0];
                        end
                    end
                end
                S_CALC: begin
                    wdata_q   <= upd;
                    wr_addr_q <= {s_q, a_q};
                end
                S_WRITE: begin
                    q_new_q <= wdata_q;
                    best_q  <= idx_q;
                end
                default: ;
            endcase
        end
    end

    assign ram_rd_addr_o = rd_addr_q;
    assign ram_wr_addr_o = wr_addr_q;
    assign ram_wdata_o   = wdata_q;
    assign q_new_o       = q_new_q;
    assign best_action_o = best_q;

endmodule

// File: tb/tb_q_update_ctrl.sv
// Bench for q_update_ctrl: synchronous RAM model, table of update vectors, protocol and reset sequences.
module tb_q_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  state_in, next_state;
    logic [1:0]  action;
    logic [15:0] reward;
    logic        terminal;
    logic        ram_en, ram_we, busy, done;
    logic [5:0]  ram_rd_addr, ram_wr_addr;
    logic [15:0] ram_wdata, ram_rdata, q_new;
    logic [1:0]  best_action;

    int errors = 0;
    int checks = 0;

    q_update_ctrl #(.ALPHA_SHIFT(2), .GAMMA_SHIFT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .state_i       (state_in),
        .action_i      (action),
        .next_state_i  (next_state),
        .reward_i      (reward),
        .terminal_i    (terminal),
        .ram_en_o      (ram_en),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_we_o      (ram_we),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata),
        .busy_o        (busy),
        .done_o        (done),
        .best_action_o (best_action),
        .q_new_o       (q_new)
    );

    always #5 clk = ~clk;

    // RAM: registered read while enabled (0 otherwise); read-before-write on the same edge.
    logic [15:0] mem [64];
    always @(posedge clk) begin
        ram_rdata <= ram_en ? mem[ram_rd_addr] : 16'h0000;
        if (ram_we)
            mem[ram_wr_addr] <= ram_wdata;
    end

    typedef struct {
        string       name;
        logic [3:0]  s;
        logic [1:0]  a;
        logic [3:0]  sp;
        logic [15:0] r;
        logic        term;
        logic [15:0] qsp0, qsp1, qsp2, qsp3;
        logic [15:0] qcur;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_best;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input vec_t v);
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[{v.sp, 2'd0}] = v.qsp0;
        mem[{v.sp, 2'd1}] = v.qsp1;
        mem[{v.sp, 2'd2}] = v.qsp2;
        mem[{v.sp, 2'd3}] = v.qsp3;
        mem[{v.s, v.a}]   = v.qcur;
    endtask

    task automatic drive_start(input vec_t v);
        state_in   = v.s;
        action     = v.a;
        next_state = v.sp;
        reward     = v.r;
        terminal   = v.term;
        start      = 1'b1;
    endtask

    // One full update; cycle k is the k-th cycle after the one in which start is high.
    task automatic run_op(input vec_t v, input bit proto);
        int we_cnt, done_cnt, we_k, done_k;
        logic [5:0]  wa;
        logic [15:0] wd, qn;
        logic [1:0]  ba;
        logic        en_log[13];
        logic [5:0]  addr_log[13];
        logic        busy_log[13];
        logic [5:0]  exp_addr[6];
        we_cnt = 0; done_cnt = 0; we_k = -1; done_k = -1;
        wa = '0; wd = '0; qn = '0; ba = '0;
        preload(v);
        @(negedge clk);
        drive_start(v);
        en_log[0] = ram_en;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            en_log[k]   = ram_en;
            addr_log[k] = ram_rd_addr;
            busy_log[k] = busy;
            if (ram_we) begin
                we_cnt++; we_k = k; wa = ram_wr_addr; wd = ram_wdata;
            end
            if (done) begin
                done_cnt++; done_k = k; qn = q_new; ba = best_action;
            end
            start = (proto && k == 3) ? 1'b1 : 1'b0;
        end
        chk({v.name, " write count"}, we_cnt, 1);
        chk({v.name, " write cycle"}, we_k, 8);
        chk({v.name, " write addr"}, int'(wa), int'({v.s, v.a}));
        chk({v.name, " write data"}, int'(wd), int'(v.exp_wdata));
        chk({v.name, " done count"}, done_cnt, 1);
        chk({v.name, " done cycle"}, done_k, 9);
        chk({v.name, " q_new"}, int'(qn), int'(v.exp_wdata));
        chk({v.name, " best_action"}, int'(ba), int'(v.exp_best));
        chk({v.name, " busy T+9"}, int'(busy_log[9]), 1);
        chk({v.name, " busy T+10"}, int'(busy_log[10]), 0);
        chk({v.name, " ram content"}, int'(mem[{v.s, v.a}]), int'(v.exp_wdata));
        chk({v.name, " q_new held"}, int'(q_new), int'(v.exp_wdata));
        if (proto) begin
            exp_addr[1] = {v.s, v.a};
            for (int i = 0; i < 4; i++) exp_addr[i + 2] = {v.sp, i[1:0]};
            for (int k = 1; k <= 5; k++)
                chk($sformatf("%s rd_addr T+%0d", v.name, k), int'(addr_log[k]), int'(exp_addr[k]));
            chk({v.name, " ram_en T+0"}, int'(en_log[0]), 0);
            for (int k = 1; k <= 12; k++)
                chk($sformatf("%s ram_en T+%0d", v.name, k), int'(en_log[k]), (k <= 6) ? 1 : 0);
        end
    endtask

    initial begin
        //          name       s     a     sp    r         term  qsp0      qsp1      qsp2      qsp3      qcur      wdata     best
        vecs[0] = '{"basic",  4'd3, 2'd1, 4'd5, 16'h0040, 1'b0, 16'h0080, 16'h0200, 16'h0200, 16'hFF00, 16'h0100, 16'h0110, 2'd1};
        vecs[1] = '{"terminal", 4'd3, 2'd1, 4'd5, 16'h0040, 1'b1, 16'h0080, 16'h0200, 16'h0200, 16'hFF00, 16'h0100, 16'h00D0, 2'd1};
        vecs[2] = '{"sat_pos", 4'd1, 2'd2, 4'd7, 16'h7000, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7F00, 16'h7F3F, 2'd0};
        vecs[3] = '{"sat_neg", 4'd9, 2'd3, 4'd12, 16'h8000, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'hE000, 2'd0};
        vecs[4] = '{"same_s", 4'd2, 2'd0, 4'd2, 16'h0000, 1'b0, 16'h0100, 16'h0300, 16'h0000, 16'h0000, 16'h0100, 16'h0120, 2'd1};

        rst = 1'b1; start = 1'b0; state_in = '0; action = '0; next_state = '0;
        reward = '0; terminal = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset ram_en", int'(ram_en), 0);
        chk("reset ram_we", int'(ram_we), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_addr", int'(ram_rd_addr), 0);
        chk("reset wr_addr", int'(ram_wr_addr), 0);
        chk("reset wdata", int'(ram_wdata), 0);
        chk("reset q_new", int'(q_new), 0);
        chk("reset best", int'(best_action), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_op(vecs[i], 1'b0);

        // Second start pulse at T+3 must be ignored; also checks read address/enable timing.
        run_op(vecs[0], 1'b1);

        // Reset during CALC: no write, outputs cleared, then a clean update.
        begin
            int we_seen;
            we_seen = 0;
            preload(vecs[0]);
            @(negedge clk);
            drive_start(vecs[0]);
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (ram_we) we_seen++;
                start = 1'b0;
                if (k == 7) begin
                    chk("midrst busy before", int'(busy), 1);
                    rst = 1'b1;
                end
                if (k == 8) begin
                    chk("midrst busy", int'(busy), 0);
                    chk("midrst q_new", int'(q_new), 0);
                    chk("midrst best", int'(best_action), 0);
                    rst = 1'b0;
                end
            end
            chk("midrst write count", we_seen, 0);
            chk("midrst ram unchanged", int'(mem[13]), 16'h0100);
        end
        run_op(vecs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
